// File: rtl/seq_detector_param_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_pkg;

    localparam logic MODE_MEALY = 1'b1;
    localparam logic MODE_MOORE = 1'b0;
    localparam logic OVL_ON     = 1'b1;
    localparam logic OVL_OFF    = 1'b0;

    localparam logic [3:0] DEF_PATTERN = 4'b1101;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial data, configuration and result bundle of the pattern detector.
interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             in;
    logic             in_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_ovl;
    logic             cfg_mealy;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output in, in_valid, cfg_load, cfg_pattern, cfg_ovl, cfg_mealy, cnt_clr,
        input  out, match_cnt
    );

    modport slave (
        input  in, in_valid, cfg_load, cfg_pattern, cfg_ovl, cfg_mealy, cnt_clr,
        output out, match_cnt
    );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
    import seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= CNT_W'(sat_inc(32'(cnt), CNT_MAX));
        end
    end
endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap/non-overlap matching,
// Mealy or Moore output and a saturating match counter.
module seq_detector_param
    import seq_pkg::*;
#(
    parameter int               PAT_W     = 4,
    parameter int               CNT_W     = 8,
    parameter logic [PAT_W-1:0] DEF_PAT   = PAT_W'(DEF_PATTERN),
    parameter logic             DEF_OVL   = OVL_ON,
    parameter logic             DEF_MEALY = MODE_MEALY
) (
    input logic                 clk,
    input logic                 rst_n,
    seq_detector_param_if.slave bus
);
    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat_reg;
    logic              ovl_reg;
    logic              mealy_reg;
    logic              out_q;
    logic [PAT_W-1:0]  cand;
    logic              hit;

    assign cand = {hist[PAT_W-2:0], bus.in};
    assign hit  = bus.in_valid & rst_n & ~bus.cfg_load & (fill >= FILL_NEED) & (cand == pat_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist      <= '0;
            fill      <= '0;
            pat_reg   <= DEF_PAT;
            ovl_reg   <= DEF_OVL;
            mealy_reg <= DEF_MEALY;
        end else if (bus.cfg_load) begin
            hist      <= '0;
            fill      <= '0;
            pat_reg   <= bus.cfg_pattern;
            ovl_reg   <= bus.cfg_ovl;
            mealy_reg <= bus.cfg_mealy;
        end else if (bus.in_valid) begin
            hist <= cand;
            // Non-overlap mode discards the matched bits so the next match needs fresh ones.
            if (hit && (ovl_reg == OVL_OFF)) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.cfg_load) begin
            out_q <= 1'b0;
        end else begin
            out_q <= hit;
        end
    end

    // Gate with rst_n so a pending Moore pulse never shows while reset is held.
    assign bus.out = rst_n & ((mealy_reg == MODE_MEALY) ? hit : out_q);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (bus.cnt_clr | bus.cfg_load),
        .cnt   (bus.match_cnt)
    );
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed scoreboard bench for seq_detector_param (PAT_W=4, CNT_W=3).
module tb_seq_detector_param;
    import seq_pkg::*;

    logic clk;
    logic rst_n;

    seq_detector_param_if #(.PAT_W(4), .CNT_W(3)) bus ();

    seq_detector_param #(
        .PAT_W (4),
        .CNT_W (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       out;
        logic [2:0] cnt;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   nstep    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.out !== e.out) begin
                    failures++;
                    $display("FAIL step%0d out: got %b want %b", e.idx, bus.out, e.out);
                end
                checks++;
                if (bus.match_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL step%0d match_cnt: got %0d want %0d", e.idx, bus.match_cnt, e.cnt);
                end
            end
        end
    end

    task automatic set_cfg(input logic [3:0] pat, input logic ovl, input logic mealy);
        bus.cfg_pattern = pat;
        bus.cfg_ovl     = ovl;
        bus.cfg_mealy   = mealy;
    endtask

    task automatic step(input logic v, input logic b, input logic eo, input int ec,
                        input logic rst = 1'b1, input logic ld = 1'b0, input logic clr = 1'b0);
        exp_t e;
        rst_n        = rst;
        bus.cfg_load = ld;
        bus.cnt_clr  = clr;
        bus.in_valid = v;
        bus.in       = b;
        e.out = eo;
        e.cnt = 3'(ec);
        e.idx = nstep;
        sb.push_back(e);
        nstep++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ec;
        rst_n        = 1'b0;
        bus.in       = 1'b0;
        bus.in_valid = 1'b0;
        bus.cfg_load = 1'b0;
        bus.cnt_clr  = 1'b0;
        set_cfg(4'b0000, OVL_ON, MODE_MEALY);
        @(posedge clk);
        #1;

        // reset state: out stays low even with a valid bit presented
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);

        // 1: default 1101, overlap, Mealy
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 1, 1);
        step(0, 0, 0, 2);

        // 2: non-overlap Mealy 1101
        set_cfg(4'b1101, OVL_OFF, MODE_MEALY);
        step(0, 0, 0, 2, 1, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 1, 1);
        step(0, 0, 0, 2);

        // 3: Moore, overlap
        set_cfg(4'b1101, OVL_ON, MODE_MOORE);
        step(0, 0, 0, 2, 1, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);

        // 4: in_valid gaps, back to Mealy
        set_cfg(4'b1101, OVL_ON, MODE_MEALY);
        step(0, 0, 0, 1, 1, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 1);

        // 5: pattern 1010, saturation at 7, clear beats coincident hit
        set_cfg(4'b1010, OVL_ON, MODE_MEALY);
        step(0, 0, 0, 1, 1, 1);
        for (int k = 1; k <= 20; k++) begin
            ec = (k < 4) ? 0 : (((k - 3) / 2 > 7) ? 7 : (k - 3) / 2);
            step(1, logic'(k % 2), logic'((k >= 4) && (k % 2 == 0)), ec);
        end
        step(1, 1, 0, 7);
        step(1, 0, 1, 7, 1, 0, 1);
        step(0, 0, 0, 0);

        // 6: reset and reconfiguration mid-stream
        set_cfg(4'b1101, OVL_ON, MODE_MEALY);
        step(0, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        set_cfg(4'b0110, OVL_ON, MODE_MEALY);
        step(1, 1, 0, 0, 1, 1);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 0, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
